// File: rtl/mmss_display_mux_if.sv
// Display-side bus for the mm:ss display multiplexer.
// The stopwatch side drives binary mm/ss; the mux drives the active-low digit/segment/dp pins.
interface mmss_display_mux_if;
    logic [5:0] mm;
    logic [5:0] ss;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    modport master (output mm, output ss, input an, input seg, input dp);
    modport slave  (input mm, input ss, output an, output seg, output dp);
endinterface

// File: rtl/mmss_display_mux.sv
// 4-digit common-anode 7-segment scanner for an mm:ss value, with a per-scan input snapshot.
// Optional MMSS_LEADING_ZERO_BLANK_EN blanks a zero minutes-tens digit.
module mmss_display_mux #(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input logic               clk,
    input logic               rst,
    mmss_display_mux_if.slave bus
);

    localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [6:0] SEG_DARK = 7'b1111111;
    localparam logic [6:0] SEG_DASH = 7'b0111111;

    logic [CNT_W-1:0] cnt;
    logic [1:0]       idx;
    logic [5:0]       snap_mm;
    logic [5:0]       snap_ss;
    logic [3:0]       an_q;
    logic [6:0]       seg_q;
    logic             dp_q;

    logic             cnt_last_c;
    logic [5:0]       sel_val_c;
    logic [5:0]       tens_base_c;
    logic [3:0]       tens_c;
    logic [3:0]       units_c;
    logic [3:0]       digit_c;
    logic             oor_c;
    logic [6:0]       seg_c;
    logic [3:0]       an_c;
    logic             dp_c;

    assign cnt_last_c = (cnt == CNT_LAST);

    // BCD split of the selected field by range compares, then segment encode.
    always_comb begin
        sel_val_c   = idx[1] ? snap_mm : snap_ss;
        tens_c      = 4'd0;
        tens_base_c = 6'd0;
        if (sel_val_c >= 6'd50) begin
            tens_c      = 4'd5;
            tens_base_c = 6'd50;
        end else if (sel_val_c >= 6'd40) begin
            tens_c      = 4'd4;
            tens_base_c = 6'd40;
        end else if (sel_val_c >= 6'd30) begin
            tens_c      = 4'd3;
            tens_base_c = 6'd30;
        end else if (sel_val_c >= 6'd20) begin
            tens_c      = 4'd2;
            tens_base_c = 6'd20;
        end else if (sel_val_c >= 6'd10) begin
            tens_c      = 4'd1;
            tens_base_c = 6'd10;
        end
        units_c = 4'(sel_val_c - tens_base_c);
        oor_c   = (sel_val_c > 6'd59);
        digit_c = idx[0] ? tens_c : units_c;

        case (digit_c)
            4'd0:    seg_c = 7'b1000000;
            4'd1:    seg_c = 7'b1111001;
            4'd2:    seg_c = 7'b0100100;
            4'd3:    seg_c = 7'b0110000;
            4'd4:    seg_c = 7'b0011001;
            4'd5:    seg_c = 7'b0010010;
            4'd6:    seg_c = 7'b0000010;
            4'd7:    seg_c = 7'b1111000;
            4'd8:    seg_c = 7'b0000000;
            4'd9:    seg_c = 7'b0010000;
            default: seg_c = SEG_DARK;
        endcase

        if (oor_c) begin
            seg_c = SEG_DASH;
`ifdef MMSS_LEADING_ZERO_BLANK_EN
        end else if ((idx == 2'd3) && (tens_c == 4'd0)) begin
            seg_c = SEG_DARK;
`endif
        end

        an_c = ~(4'b0001 << idx);
        dp_c = (idx != 2'd2);
    end

    // Refresh counter, digit index and snapshot; snapshot only on the 3->0 wrap.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt     <= '0;
            idx     <= 2'd0;
            snap_mm <= 6'd0;
            snap_ss <= 6'd0;
        end else if (cnt_last_c) begin
            cnt <= '0;
            idx <= idx + 2'd1;
            if (idx == 2'd3) begin
                snap_mm <= bus.mm;
                snap_ss <= bus.ss;
            end
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Output registers: one cycle behind idx/snap.
    always_ff @(posedge clk) begin
        if (!rst) begin
            an_q  <= 4'b1111;
            seg_q <= SEG_DARK;
            dp_q  <= 1'b1;
        end else begin
            an_q  <= an_c;
            seg_q <= seg_c;
            dp_q  <= dp_c;
        end
    end

    assign bus.an  = an_q;
    assign bus.seg = seg_q;
    assign bus.dp  = dp_q;

endmodule
